// File: rtl/program_run_controller.sv
// Load-and-run sequencer for the SAP-1.5 computer: streams a program image into
// RAM with the core held in reset, releases reset after a fixed hold, then counts
// run cycles until the core halts or the cycle budget runs out.
module program_run_controller #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MAX_CYCLES = 50,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  input  logic                  cpu_halt,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int unsigned LCW   = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned HCW   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t                state, state_nxt;
  logic [HCW-1:0]        hold_cnt, hold_nxt;
  logic [LCW-1:0]        load_nxt;
  logic [CNT_WIDTH-1:0]  cyc_nxt;
  logic                  ovf_nxt;
  logic                  we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next-value logic; load_count doubles as the write address
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    load_nxt  = load_count;
    cyc_nxt   = cycle_count;
    ovf_nxt   = overflow;
    we_nxt    = 1'b0;
    addr_nxt  = ram_addr;
    wdata_nxt = ram_wdata;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state_nxt = S_LOAD;
            load_nxt  = '0;
            cyc_nxt   = '0;
            ovf_nxt   = 1'b0;
            hold_nxt  = '0;
            addr_nxt  = '0;
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready) begin
            we_nxt    = 1'b1;
            addr_nxt  = load_count[ADDR_WIDTH-1:0];
            wdata_nxt = s_data;
            load_nxt  = load_count + LCW'(1);
            if (s_last) begin
              state_nxt = S_HOLD;
            end else if (load_count == LCW'(DEPTH - 1)) begin
              // RAM full before the image ended: stop accepting, never wrap
              ovf_nxt   = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == HCW'(RESET_HOLD - 1)) state_nxt = S_RUN;
          else                                  hold_nxt  = hold_cnt + HCW'(1);
        end
        S_RUN: begin
          cyc_nxt = cycle_count + CNT_WIDTH'(1);
          // Halt takes precedence over budget expiry in the same cycle
          if (cpu_halt)                                state_nxt = S_DONE;
          else if (cyc_nxt == CNT_WIDTH'(MAX_CYCLES)) state_nxt = S_TIMEOUT;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered datapath and status outputs, derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      load_count  <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      s_ready     <= 1'b0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      hold_cnt    <= hold_nxt;
      load_count  <= load_nxt;
      cycle_count <= cyc_nxt;
      overflow    <= ovf_nxt;
      ram_we      <= we_nxt;
      ram_addr    <= addr_nxt;
      ram_wdata   <= wdata_nxt;
      s_ready     <= (state_nxt == S_LOAD);
      cpu_reset   <= (state_nxt inside {S_IDLE, S_LOAD, S_HOLD});
      busy        <= (state_nxt inside {S_LOAD, S_HOLD, S_RUN});
      done        <= (state_nxt == S_DONE);
      timeout     <= (state_nxt == S_TIMEOUT);
    end
  end

endmodule
